// File: rtl/fixed_point_divider_param.sv
// Unsigned fixed-point divider: Q = floor(A*2^FRAC / B), restoring shift-subtract,
// one quotient bit per clock, with start/busy/done handshake, remainder, dz and ov flags.
module fixed_point_divider_param #(
    parameter int WIDTH    = 10,
    parameter int FRAC     = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             ov,
    output logic             dz,
    output logic [1:0]       o_dbg_state
);
    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: start is accepted only in IDLE or DONE; busy is high for the N
    // iteration cycles; done pulses for exactly one cycle when Q/R/ov/dz become valid.
    state_t r_state, w_state_next;

    logic [WIDTH-1:0] r_op_a, r_op_b, r_wb;
    logic [N-1:0]     r_dvd;
    // The last quotient bit goes straight into the result registers, so only
    // N-1 bits ever need to be held between iterations.
    logic [N-2:0]     r_quo;
    // The remainder after each step is below B, so WIDTH bits hold it; the
    // WIDTH+1-bit trial value T is formed combinationally.
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q, r_r;
    logic             r_ov, r_dz;

    logic             w_accept, w_b_zero, w_last, w_ge, w_ov;
    logic [WIDTH:0]   w_t;
    logic [WIDTH-1:0] w_acc_next;
    logic [N-1:0]     w_quo_next;

    assign w_accept   = start && (r_state != S_RUN);
    assign w_b_zero   = (r_op_b == '0);
    assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(N - 1));
    assign w_t        = {r_acc, r_dvd[N-1]};
    assign w_ge       = (w_t >= {1'b0, r_wb});
    // When T >= B the difference is below B, so WIDTH-bit arithmetic is exact.
    assign w_acc_next = w_ge ? (w_t[WIDTH-1:0] - r_wb) : w_t[WIDTH-1:0];
    assign w_quo_next = {r_quo, w_ge};
    assign w_ov       = |w_quo_next[N-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_next = S_IDLE;
                if (start) begin
                    w_state_next = w_b_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_wb   <= '0;
            r_dvd  <= '0;
            r_quo  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_ov   <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            if (ld_a) r_op_a <= A;
            if (ld_b) r_op_b <= B;
            if (w_accept && w_b_zero) begin
                r_q  <= '1;
                r_r  <= '0;
                r_ov <= 1'b0;
                r_dz <= 1'b1;
            end else if (w_accept) begin
                // Working copies are taken from the operand registers as they were before this edge.
                r_dvd <= {r_op_a, {FRAC{1'b0}}};
                r_wb  <= r_op_b;
                r_acc <= '0;
                r_quo <= '0;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_dvd <= r_dvd << 1;
                r_acc <= w_acc_next;
                r_quo <= w_quo_next[N-2:0];
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_ov <= w_ov;
                    r_q  <= (w_ov && SATURATE) ? '1 : w_quo_next[WIDTH-1:0];
                    r_r  <= w_acc_next;
                    r_dz <= 1'b0;
                end
            end
        end
    end

    assign Q           = r_q;
    assign R           = r_r;
    assign ov          = r_ov;
    assign dz          = r_dz;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign o_dbg_state = r_state;
endmodule
